// File: rtl/periph_reg_xbar.sv
// OBI-to-register-bus crossbar: one outstanding OBI access decoded onto NPORTS valid/ready ports.
// Optional access watchdog enabled by defining PERIPH_XBAR_TIMEOUT_EN.
module periph_reg_xbar #(
  parameter int unsigned          NPORTS         = 8,
  parameter logic [NPORTS*32-1:0] ADDR_BASES     = '0,
  parameter logic [NPORTS*32-1:0] ADDR_MASKS     = '1,
  parameter int unsigned          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]          ERR_RDATA      = 32'hBADCAB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 obi_req_i,
  output logic                 obi_gnt_o,
  input  logic [31:0]          obi_addr_i,
  input  logic                 obi_we_i,
  input  logic [3:0]           obi_be_i,
  input  logic [31:0]          obi_wdata_i,
  output logic                 obi_rvalid_o,
  output logic [31:0]          obi_rdata_o,
  output logic                 obi_err_o,
  output logic [NPORTS-1:0]    reg_valid_o,
  output logic                 reg_write_o,
  output logic [31:0]          reg_addr_o,
  output logic [31:0]          reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  input  logic [NPORTS-1:0]    reg_ready_i,
  input  logic [NPORTS*32-1:0] reg_rdata_i,
  input  logic [NPORTS-1:0]    reg_error_i,
  output logic [NPORTS-1:0]    port_busy_o,
  output logic                 timeout_irq_o
);

  localparam int unsigned SEL_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  if (NPORTS < 1 || NPORTS > 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("periph_reg_xbar: illegal NPORTS or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NPORTS-1:0]  valid_q, valid_d;
  logic               reg_write_q, reg_write_d;
  logic [31:0]        reg_addr_q, reg_addr_d;
  logic [31:0]        reg_wdata_q, reg_wdata_d;
  logic [3:0]         reg_wstrb_q, reg_wstrb_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               hit;
  logic [SEL_W-1:0]   hit_idx;
  logic [31:0]        sel_rdata;

`ifdef PERIPH_XBAR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
`endif

  // Address decode; iterating downwards lets the lowest matching index win
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
      if ((obi_addr_i & ADDR_MASKS[32*i +: 32]) == ADDR_BASES[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign sel_rdata = reg_rdata_i[32*int'(sel_q) +: 32];

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    reg_write_d = reg_write_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wstrb_d = reg_wstrb_q;
    valid_d     = '0;
    rvalid_d    = 1'b0;
    rdata_d     = '0;
    err_d       = 1'b0;
    obi_gnt_o   = 1'b0;
`ifdef PERIPH_XBAR_TIMEOUT_EN
    cnt_d       = cnt_q;
    irq_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        obi_gnt_o = obi_req_i;
        if (obi_req_i) begin
          reg_write_d = obi_we_i;
          reg_addr_d  = obi_addr_i;
          reg_wdata_d = obi_wdata_i;
          reg_wstrb_d = obi_be_i;
          if (hit) begin
            state_d = ACCESS;
            sel_d   = hit_idx;
`ifdef PERIPH_XBAR_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = RESP;
            rdata_d = ERR_RDATA;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
`ifdef PERIPH_XBAR_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (reg_ready_i[sel_q]) begin
          state_d = RESP;
          rdata_d = reg_write_q ? 32'h0 : sel_rdata;
          err_d   = reg_error_i[sel_q];
        end
`ifdef PERIPH_XBAR_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          irq_d   = 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rvalid_d = (state_d == RESP);
    // Shared payload is only visible while an access is in flight
    if (state_d == ACCESS) begin
      valid_d = NPORTS'(1) << sel_d;
    end else begin
      reg_write_d = 1'b0;
      reg_addr_d  = '0;
      reg_wdata_d = '0;
      reg_wstrb_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      valid_q     <= '0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef PERIPH_XBAR_TIMEOUT_EN
      cnt_q       <= '0;
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wstrb_q <= reg_wstrb_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef PERIPH_XBAR_TIMEOUT_EN
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
`endif
    end
  end

  assign reg_valid_o  = valid_q;
  assign port_busy_o  = valid_q;
  assign reg_write_o  = reg_write_q;
  assign reg_addr_o   = reg_addr_q;
  assign reg_wdata_o  = reg_wdata_q;
  assign reg_wstrb_o  = reg_wstrb_q;
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;
`ifdef PERIPH_XBAR_TIMEOUT_EN
  assign timeout_irq_o = irq_q;
`else
  assign timeout_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_periph_reg_xbar.sv
// Directed bench for periph_reg_xbar: 4 ports, TIMEOUT_CYCLES=16; expectations follow PERIPH_XBAR_TIMEOUT_EN.
module tb_periph_reg_xbar;

  localparam int unsigned NP = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              obi_req_i;
  logic              obi_gnt_o;
  logic [31:0]       obi_addr_i;
  logic              obi_we_i;
  logic [3:0]        obi_be_i;
  logic [31:0]       obi_wdata_i;
  logic              obi_rvalid_o;
  logic [31:0]       obi_rdata_o;
  logic              obi_err_o;
  logic [NP-1:0]     reg_valid_o;
  logic              reg_write_o;
  logic [31:0]       reg_addr_o;
  logic [31:0]       reg_wdata_o;
  logic [3:0]        reg_wstrb_o;
  logic [NP-1:0]     reg_ready_i;
  logic [NP*32-1:0]  reg_rdata_i;
  logic [NP-1:0]     reg_error_i;
  logic [NP-1:0]     port_busy_o;
  logic              timeout_irq_o;

  int n_vec = 0;
  int n_err = 0;

  periph_reg_xbar #(
    .NPORTS        (NP),
    .ADDR_BASES    ({32'h2000_0010, 32'h2000_0200, 32'h2000_0100, 32'h2000_0000}),
    .ADDR_MASKS    ({32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00}),
    .TIMEOUT_CYCLES(16),
    .ERR_RDATA     (32'hBADCAB1E)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .reg_valid_o  (reg_valid_o),
    .reg_write_o  (reg_write_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_wstrb_o  (reg_wstrb_o),
    .reg_ready_i  (reg_ready_i),
    .reg_rdata_i  (reg_rdata_i),
    .reg_error_i  (reg_error_i),
    .port_busy_o  (port_busy_o),
    .timeout_irq_o(timeout_irq_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdata(input int p, input logic [31:0] d);
    reg_rdata_i[32*p +: 32] = d;
  endtask

  task automatic start_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
    obi_req_i   = 1'b1;
    obi_addr_i  = a;
    obi_we_i    = we;
    obi_be_i    = be;
    obi_wdata_i = wd;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    obi_req_i = 1'b0;
    tick;
    tick;
    n_vec++;
    if ({reg_valid_o, port_busy_o, obi_rvalid_o, obi_err_o, timeout_irq_o, obi_gnt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b/%b rv=%b err=%b irq=%b gnt=%b, want all 0",
               reg_valid_o, port_busy_o, obi_rvalid_o, obi_err_o, timeout_irq_o, obi_gnt_o);
    end
    n_vec++;
    if ({obi_rdata_o, reg_addr_o, reg_wdata_o, reg_wstrb_o, reg_write_o} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h wstrb=%h we=%b, want all 0",
               obi_rdata_o, reg_addr_o, reg_wdata_o, reg_wstrb_o, reg_write_o);
    end
    rst_i = 1'b0;
    tick;
  endtask

  task automatic test_read_port2;
    reg_ready_i = '1;
    set_rdata(2, 32'h1234_5678);
    start_req(32'h2000_0204, 1'b0, 4'hF, 32'h0);
    #1;
    n_vec++;
    if (obi_gnt_o !== 1'b1) begin n_err++; $display("FAIL rd2_gnt: got %b want 1", obi_gnt_o); end
    tick;
    obi_req_i = 1'b0;
    n_vec++;
    if ({reg_valid_o, port_busy_o, reg_addr_o, reg_write_o} !== {4'b0100, 4'b0100, 32'h2000_0204, 1'b0}) begin
      n_err++;
      $display("FAIL rd2_access: got valid=%b busy=%b addr=%h we=%b want 0100 0100 20000204 0",
               reg_valid_o, port_busy_o, reg_addr_o, reg_write_o);
    end
    tick;
    n_vec++;
    if ({obi_rvalid_o, obi_rdata_o, obi_err_o, reg_valid_o} !== {1'b1, 32'h1234_5678, 1'b0, 4'b0000}) begin
      n_err++;
      $display("FAIL rd2_resp: got rv=%b rdata=%h err=%b valid=%b want 1 12345678 0 0000",
               obi_rvalid_o, obi_rdata_o, obi_err_o, reg_valid_o);
    end
    tick;
    n_vec++;
    if ({obi_rvalid_o, obi_rdata_o, obi_err_o} !== '0) begin
      n_err++;
      $display("FAIL rd2_idle: got rv=%b rdata=%h err=%b want 0 0 0", obi_rvalid_o, obi_rdata_o, obi_err_o);
    end
  endtask

  task automatic test_decode_err;
    start_req(32'h3000_0000, 1'b1, 4'hF, 32'hDEAD_BEEF);
    #1;
    n_vec++;
    if (obi_gnt_o !== 1'b1) begin n_err++; $display("FAIL dec_gnt: got %b want 1", obi_gnt_o); end
    tick;
    obi_req_i = 1'b0;
    n_vec++;
    if ({obi_rvalid_o, obi_err_o, obi_rdata_o, reg_valid_o} !== {1'b1, 1'b1, 32'hBADCAB1E, 4'b0000}) begin
      n_err++;
      $display("FAIL dec_resp: got rv=%b err=%b rdata=%h valid=%b want 1 1 badcab1e 0000",
               obi_rvalid_o, obi_err_o, obi_rdata_o, reg_valid_o);
    end
    tick;
    n_vec++;
    if ({obi_rvalid_o, reg_valid_o} !== '0) begin
      n_err++;
      $display("FAIL dec_after: got rv=%b valid=%b want 0 0000", obi_rvalid_o, reg_valid_o);
    end
  endtask

  task automatic test_priority;
    reg_ready_i = '1;
    set_rdata(0, 32'hAAAA_0000);
    set_rdata(3, 32'hAAAA_0003);
    start_req(32'h2000_0010, 1'b0, 4'hF, 32'h0);
    tick;
    obi_req_i = 1'b0;
    n_vec++;
    if (reg_valid_o !== 4'b0001) begin
      n_err++;
      $display("FAIL prio_valid: got %b want 0001", reg_valid_o);
    end
    tick;
    n_vec++;
    if ({obi_rvalid_o, obi_rdata_o} !== {1'b1, 32'hAAAA_0000}) begin
      n_err++;
      $display("FAIL prio_resp: got rv=%b rdata=%h want 1 aaaa0000", obi_rvalid_o, obi_rdata_o);
    end
    tick;
  endtask

  task automatic test_timeout;
`ifdef PERIPH_XBAR_TIMEOUT_EN
    localparam int NWAIT = 16;
`else
    localparam int NWAIT = 40;
`endif
    reg_ready_i = '0;
    set_rdata(1, 32'h600D_F00D);
    start_req(32'h2000_0100, 1'b0, 4'hF, 32'h0);
    tick;
    obi_req_i = 1'b0;
    for (int c = 1; c <= NWAIT; c++) begin
      if (c > 1) tick;
      n_vec++;
      if ({reg_valid_o, port_busy_o, obi_rvalid_o, timeout_irq_o} !== {4'b0010, 4'b0010, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL tmo_wait[%0d]: got valid=%b busy=%b rv=%b irq=%b want 0010 0010 0 0",
                 c, reg_valid_o, port_busy_o, obi_rvalid_o, timeout_irq_o);
      end
    end
`ifdef PERIPH_XBAR_TIMEOUT_EN
    tick;
    n_vec++;
    if ({obi_rvalid_o, obi_err_o, timeout_irq_o, obi_rdata_o, reg_valid_o} !==
        {1'b1, 1'b1, 1'b1, 32'hBADCAB1E, 4'b0000}) begin
      n_err++;
      $display("FAIL tmo_abort: got rv=%b err=%b irq=%b rdata=%h valid=%b want 1 1 1 badcab1e 0000",
               obi_rvalid_o, obi_err_o, timeout_irq_o, obi_rdata_o, reg_valid_o);
    end
    tick;
    n_vec++;
    if ({obi_rvalid_o, timeout_irq_o} !== 2'b00) begin
      n_err++;
      $display("FAIL tmo_after: got rv=%b irq=%b want 0 0", obi_rvalid_o, timeout_irq_o);
    end
`else
    reg_ready_i[1] = 1'b1;
    tick;
    n_vec++;
    if ({obi_rvalid_o, obi_err_o, timeout_irq_o, obi_rdata_o} !== {1'b1, 1'b0, 1'b0, 32'h600D_F00D}) begin
      n_err++;
      $display("FAIL tmo_late_ready: got rv=%b err=%b irq=%b rdata=%h want 1 0 0 600df00d",
               obi_rvalid_o, obi_err_o, timeout_irq_o, obi_rdata_o);
    end
    tick;
`endif
  endtask

  task automatic test_reset_in_access;
    reg_ready_i = '0;
    start_req(32'h2000_0104, 1'b0, 4'hF, 32'h0);
    tick;
    obi_req_i = 1'b0;
    tick;
    n_vec++;
    if (reg_valid_o !== 4'b0010) begin
      n_err++;
      $display("FAIL rst_acc_pre: got valid=%b want 0010", reg_valid_o);
    end
    rst_i = 1'b1;
    tick;
    n_vec++;
    if ({reg_valid_o, port_busy_o, obi_rvalid_o} !== '0) begin
      n_err++;
      $display("FAIL rst_acc_clear: got valid=%b busy=%b rv=%b want 0", reg_valid_o, port_busy_o, obi_rvalid_o);
    end
    rst_i = 1'b0;
    tick;
    n_vec++;
    if (obi_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_acc_norv: got %b want 0", obi_rvalid_o); end
    reg_ready_i = '1;
    set_rdata(1, 32'h55AA_33CC);
    start_req(32'h2000_0104, 1'b0, 4'hF, 32'h0);
    #1;
    n_vec++;
    if (obi_gnt_o !== 1'b1) begin n_err++; $display("FAIL rst_acc_gnt: got %b want 1", obi_gnt_o); end
    tick;
    obi_req_i = 1'b0;
    tick;
    n_vec++;
    if ({obi_rvalid_o, obi_rdata_o, obi_err_o} !== {1'b1, 32'h55AA_33CC, 1'b0}) begin
      n_err++;
      $display("FAIL rst_acc_read: got rv=%b rdata=%h err=%b want 1 55aa33cc 0", obi_rvalid_o, obi_rdata_o, obi_err_o);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_v  [3] = '{32'h2000_0004, 32'h2000_0108, 32'h2000_0220};
    logic        we_v [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0]  be_v [3] = '{4'hF, 4'hF, 4'h3};
    logic [31:0] wd_v [3] = '{32'h0, 32'h0, 32'hCAFE_F00D};
    logic [3:0]  ev_v [3] = '{4'b0001, 4'b0010, 4'b0100};
    logic [31:0] rd_v [3] = '{32'hAAAA_0000, 32'h1111_2222, 32'h0};
    logic        er_v [3] = '{1'b0, 1'b0, 1'b1};
    reg_ready_i = '1;
    reg_error_i = 4'b0100;
    set_rdata(0, 32'hAAAA_0000);
    set_rdata(1, 32'h1111_2222);
    set_rdata(2, 32'h9999_9999);
    start_req(a_v[0], we_v[0], be_v[0], wd_v[0]);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (obi_gnt_o !== 1'b1) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b want 1", k, obi_gnt_o); end
      tick;
      n_vec++;
      if ({obi_gnt_o, reg_valid_o, reg_addr_o, reg_write_o, reg_wstrb_o, reg_wdata_o} !==
          {1'b0, ev_v[k], a_v[k], we_v[k], be_v[k], wd_v[k]}) begin
        n_err++;
        $display("FAIL b2b_access[%0d]: got gnt=%b valid=%b addr=%h we=%b be=%h wd=%h want 0 %b %h %b %h %h",
                 k, obi_gnt_o, reg_valid_o, reg_addr_o, reg_write_o, reg_wstrb_o, reg_wdata_o,
                 ev_v[k], a_v[k], we_v[k], be_v[k], wd_v[k]);
      end
      // Move the OBI payload on; the latched register payload must not follow it
      if (k < 2) start_req(a_v[k+1], we_v[k+1], be_v[k+1], wd_v[k+1]);
      tick;
      n_vec++;
      if ({obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o} !== {1'b0, 1'b1, rd_v[k], er_v[k]}) begin
        n_err++;
        $display("FAIL b2b_resp[%0d]: got gnt=%b rv=%b rdata=%h err=%b want 0 1 %h %b",
                 k, obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o, rd_v[k], er_v[k]);
      end
      if (k == 2) obi_req_i = 1'b0;
      tick;
    end
    reg_error_i = '0;
  endtask

  initial begin
    rst_i       = 1'b1;
    obi_req_i   = 1'b0;
    obi_addr_i  = '0;
    obi_we_i    = 1'b0;
    obi_be_i    = '0;
    obi_wdata_i = '0;
    reg_ready_i = '0;
    reg_error_i = '0;
    for (int p = 0; p < int'(NP); p++) set_rdata(p, 32'hAAAA_0000 + 32'(p));
    test_reset;
    test_read_port2;
    test_decode_err;
    test_priority;
    test_timeout;
    test_reset_in_access;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
